xcvr_bus_sequencer: RTL and testbench

Sequences the IC82x6 bidirectional bus transceivers on the Sm2201 ISA–CAMAC interface board. Arbitrates two requesters, the ISA host port (0) and the CAMAC cycle engine (1), for the shared transceiver group. Drives the group's `cs_n`/`dce` with guaranteed setup, strobe and direction-turnaround spacing, so the transceivers never drive while the direction is changing. All outputs are registered.

---
 rtl/xcvr_bus_sequencer.sv | 110 +++++++++++
 tb/tb_xcvr_bus_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/xcvr_bus_sequencer.sv
// Arbitrates two requesters onto a shared IC82x6 transceiver group and paces cs_n/dce
// with setup, strobe and turnaround spacing. Define XCVR_SEQ_ROUND_ROBIN_EN for round-robin ties.
module xcvr_bus_sequencer #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 3,
  parameter int unsigned TURN_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic [1:0] dir_i,
  output logic [1:0] gnt_o,
  output logic [1:0] ack_o,
  output logic       xcvr_cs_n_o,
  output logic       xcvr_dce_o,
  output logic       latch_stb_o,
  output logic       busy_o
);

  localparam int unsigned CNT_W = 5;
  localparam bit          STB_ONE = (STROBE_CYCLES == 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             win_q;

  logic             win_d;
  logic             turn_d;
  logic [CNT_W-1:0] setup_m1_d;

`ifdef XCVR_SEQ_ROUND_ROBIN_EN
  logic last_q;
`endif

  // Winner selection and SETUP length, evaluated while IDLE
  always_comb begin
`ifdef XCVR_SEQ_ROUND_ROBIN_EN
    win_d = (req_i == 2'b11) ? ~last_q : req_i[1];
`else
    win_d = ~req_i[0];
`endif
    turn_d     = (dir_i[win_d] != xcvr_dce_o);
    setup_m1_d = CNT_W'(SETUP_CYCLES - 1) + (turn_d ? CNT_W'(TURN_CYCLES) : CNT_W'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      win_q       <= 1'b0;
      gnt_o       <= 2'b00;
      ack_o       <= 2'b00;
      xcvr_cs_n_o <= 1'b1;
      xcvr_dce_o  <= 1'b0;
      latch_stb_o <= 1'b0;
      busy_o      <= 1'b0;
`ifdef XCVR_SEQ_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      ack_o       <= 2'b00;
      latch_stb_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_q    <= SETUP;
            win_q      <= win_d;
            gnt_o      <= win_d ? 2'b10 : 2'b01;
            xcvr_dce_o <= dir_i[win_d];
            cnt_q      <= setup_m1_d;
            busy_o     <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_q == CNT_W'(0)) begin
            state_q     <= STROBE;
            xcvr_cs_n_o <= 1'b0;
            cnt_q       <= CNT_W'(STROBE_CYCLES - 1);
            latch_stb_o <= xcvr_dce_o & STB_ONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        STROBE: begin
          if (cnt_q == CNT_W'(0)) begin
            state_q     <= GAP;
            xcvr_cs_n_o <= 1'b1;
            gnt_o       <= 2'b00;
            ack_o       <= win_q ? 2'b10 : 2'b01;
          end else begin
            cnt_q       <= cnt_q - CNT_W'(1);
            // Registered so the pulse lands in the final low cycle
            latch_stb_o <= xcvr_dce_o & (cnt_q == CNT_W'(1));
          end
        end
        GAP: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
`ifdef XCVR_SEQ_ROUND_ROBIN_EN
          last_q  <= win_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xcvr_bus_sequencer.sv
// Scoreboard bench for xcvr_bus_sequencer: a transaction-level model predicts each grant,
// a negedge monitor measures the DUT's cycle shape and pops/compares at every ack.
module tb_xcvr_bus_sequencer;

  localparam int unsigned SU  = 1;
  localparam int unsigned STB = 3;
  localparam int unsigned TRN = 2;
`ifdef XCVR_SEQ_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] dir;
  logic [1:0] gnt;
  logic [1:0] ack;
  logic       cs_n;
  logic       dce;
  logic       latch;
  logic       busy;

  xcvr_bus_sequencer #(
    .SETUP_CYCLES (SU),
    .STROBE_CYCLES(STB),
    .TURN_CYCLES  (TRN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .dir_i      (dir),
    .gnt_o      (gnt),
    .ack_o      (ack),
    .xcvr_cs_n_o(cs_n),
    .xcvr_dce_o (dce),
    .latch_stb_o(latch),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] gnt;
    logic       dce;
    int         setup;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_prev_dce;
  logic m_last;

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Reference arbitration: RR gives a tie to the requester that did not go last
  function automatic logic arb(input logic [1:0] p);
    if (p == 2'b11) return RR ? ~m_last : 1'b0;
    return p[1];
  endfunction

  task automatic push_grant(input logic [1:0] p, input logic [1:0] d, output logic w);
    exp_t e;
    w       = arb(p);
    e.gnt   = w ? 2'b10 : 2'b01;
    e.dce   = d[w];
    e.setup = int'(SU) + ((d[w] != m_prev_dce) ? int'(TRN) : 0);
    m_prev_dce = d[w];
    m_last     = w;
    exp_q.push_back(e);
  endtask

  // hold: req=11 held for k grants; otherwise each requester drops on its ack (or at grant if early)
  task automatic run_round(input logic [1:0] r, input logic [1:0] d, input bit hold,
                           input int k, input bit early);
    logic [1:0] pend;
    logic       w;
    int         acks;
    bit         done;
    pend = r;
    if (hold) begin
      for (int i = 0; i < k; i++) push_grant(2'b11, d, w);
    end else begin
      while (pend != 2'b00) begin
        push_grant(pend, d, w);
        pend[w] = 1'b0;
      end
    end
    req  = r;
    dir  = d;
    acks = 0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (hold) begin
        if (ack != 2'b00) acks++;
        if (acks >= k) req = 2'b00;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (ack[i] || (early && gnt[i])) req[i] = 1'b0;
          if (gnt[i]) dir[i] = dir[i] ^ 1'($urandom_range(0, 1));
        end
      end
      done = (req == 2'b00) && !busy && (gnt == 2'b00);
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL round_timeout: got busy=%0b req=%b expected idle", busy, req);
      req = 2'b00;
    end
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_gnt", int'(gnt), 0);
  endtask

  // Monitor: measures each granted cycle and scores it when its ack appears
  bit         in_txn = 1'b0;
  logic [1:0] c_gnt;
  logic       c_dce;
  int         su, st, lat_n, lat_pos;
  bit         unstable;
  exp_t       e;

  always @(negedge clk) begin
    if (rst) begin
      in_txn = 1'b0;
    end else begin
      if (!in_txn && gnt != 2'b00) begin
        in_txn = 1'b1;
        c_gnt = gnt;
        c_dce = dce;
        su = 0; st = 0; lat_n = 0; lat_pos = 0;
        unstable = 1'b0;
      end
      if (in_txn && gnt != 2'b00) begin
        if (gnt != c_gnt || dce != c_dce) unstable = 1'b1;
        if (cs_n) begin
          if (st == 0) su++;
        end else begin
          st++;
        end
        if (latch) begin
          lat_n++;
          lat_pos = st;
        end
      end
      if (!cs_n && gnt == 2'b00) chk("cs_low_without_grant", 1, 0);
      if (latch && cs_n) chk("latch_outside_strobe", 1, 0);
      if (ack != 2'b00) begin
        if (!in_txn || exp_q.size() == 0) begin
          chk("unexpected_ack", int'(ack), 0);
        end else begin
          e = exp_q.pop_front();
          chk("gnt", int'(c_gnt), int'(e.gnt));
          chk("ack", int'(ack), int'(e.gnt));
          chk("dce", int'(c_dce), int'(e.dce));
          chk("setup_len", su, e.setup);
          chk("strobe_len", st, int'(STB));
          chk("latch_count", lat_n, e.dce ? 1 : 0);
          if (e.dce) chk("latch_pos", lat_pos, int'(STB));
          chk("grant_stable", int'(unstable), 0);
          chk("gap_cs_n", int'(cs_n), 1);
          chk("gap_gnt", int'(gnt), 0);
        end
        in_txn = 1'b0;
      end
    end
  end

  initial begin
    bit found;
    logic [1:0] r;
    rst = 1'b1;
    req = 2'b00;
    dir = 2'b00;
    m_prev_dce = 1'b0;
    m_last     = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_latch", int'(latch), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_dce", int'(dce), 0);
    rst = 1'b0;
    @(negedge clk);

    run_round(2'b01, 2'b00, 1'b0, 0, 1'b0);   // write, no turnaround
    run_round(2'b10, 2'b10, 1'b0, 0, 1'b0);   // read with turnaround
    run_round(2'b11, 2'b00, 1'b1, 4, 1'b0);   // tie held
    run_round(2'b01, 2'b01, 1'b0, 0, 1'b1);   // early drop, dir toggled after grant
    run_round(2'b11, 2'b10, 1'b0, 0, 1'b1);

    // Asynchronous reset in the middle of STROBE
    req = 2'b01;
    dir = 2'b00;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      found = !cs_n;
    end
    chk("reached_strobe", int'(found), 1);
    rst = 1'b1;
    #1;
    chk("async_cs_n", int'(cs_n), 1);
    chk("async_gnt", int'(gnt), 0);
    chk("async_busy", int'(busy), 0);
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_prev_dce = 1'b0;
    m_last     = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);
    run_round(2'b11, 2'b00, 1'b0, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      r = 2'($urandom_range(1, 3));
      if (r == 2'b11 && $urandom_range(0, 2) == 0)
        run_round(2'b11, 2'($urandom_range(0, 3)), 1'b1, int'($urandom_range(2, 4)), 1'b0);
      else
        run_round(r, 2'($urandom_range(0, 3)), 1'b0, 0, 1'($urandom_range(0, 1)));
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
